fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Sits directly downstream of the 64-point R2²SDF FFT top-level and consumes its odata_en/odata_r/odata_i stream.
- The SDF pipeline emits bins in bit-reversed order. This block reorders each N-sample frame into natural bin order using a ping-pong buffer.
- Output is a contiguous N-cycle burst with a bin index and a last-bin marker, for downstream magnitude/peak logic.

Parameters:
- N, 64, FFT length; power of 2, 4..1024.
- WIDTH, 16, data word length per real/imag component.
- LOG2N, derived as log2(N), index width; not to be overridden.

Ports:
- clock  input  1  master clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
- idata_en  input  1  input sample valid; one bit-reversed FFT sample per asserted cycle.
- idata_r  input  WIDTH  input data, real.
- idata_i  input  WIDTH  input data, imag.
- odata_en  output  1  output sample valid.
- odata_r  output  WIDTH  output data, real, natural bin order.
- odata_i  output  WIDTH  output data, imag, natural bin order.
- odata_idx  output  LOG2N  bin index of the current output sample.
- odata_last  output  1  high together with odata_en on bin N-1.

Behaviour:
- Storage: two banks, each N x 2·WIDTH. The write bank is wsel and the read bank is ~wsel.
- Write side:
  - wcnt (LOG2N bits) counts accepted samples, only on cycles with idata_en=1.
  - Each sample is written at address bitrev(wcnt), LOG2N-bit reversal, into bank wsel.
  - Gaps (idata_en=0) are allowed anywhere; wcnt holds during a gap.
  - On accepting the sample with wcnt=N-1: wcnt wraps to 0, wsel toggles, and a one-cycle frame_done pulse is issued.
- Read side FSM:
  - IDLE: waits for frame_done, then goes to READ with rcnt=0 and the read bank set to the just-completed bank.
  - READ: issues one read per cycle at address rcnt, rcnt increments. After the rcnt=N-1 read it returns to IDLE.
  - If frame_done arrives in the same cycle as the rcnt=N-1 read, the FSM goes directly to READ with rcnt=0 on the new bank. This makes back-to-back frames seamless.
- Output register:
  - odata_* and odata_idx are registered one cycle after the read address is issued.
  - odata_idx equals the read address; odata_last = odata_en & (odata_idx==N-1).
- Latency: if the last sample of a frame (wcnt=N-1) is accepted at cycle c, bin n appears with odata_en=1 at cycle c+2+n, for n=0..N-1.
  - odata_en is high for exactly N consecutive cycles per frame.
- Throughput: the next frame cannot complete sooner than N cycles after the previous one, so the bank being read is never overwritten. No overflow detection is required.
- When odata_en=0: odata_r, odata_i and odata_idx hold 0, and odata_last=0.
- Reset (reset=0, asynchronous, at any time including mid-frame or mid-burst):
  - wcnt=0, wsel=0, FSM=IDLE, rcnt=0.
  - All outputs are 0.
  - Any partial input frame and any in-progress output burst is discarded.
  - RAM contents are not cleared and are never observable before being rewritten.
- Deassertion of reset is synchronised externally; the first idata_en after reset is treated as sample 0 of a new frame.

Test Plan:
- Ramp, N=64: 64 contiguous samples with idata_r=k, idata_i=63-k.
  - Required: bin n gives odata_r=bitrev6(n), so n=1 gives 32, n=2 gives 16, n=3 gives 48, n=63 gives 63; odata_i=63-odata_r.
  - Required: first odata_en 2 cycles after the last input; odata_last only on idx 63.
- Back-to-back: three frames with continuous idata_en.
  - Required: odata_en stays high for 192 consecutive cycles with no gap, and odata_idx runs 0..63 three times.
- Gapped input: same ramp with idata_en toggling every other cycle.
  - Required: output data identical to the ramp test, and the burst still starts 2 cycles after the 64th accepted sample.
- Reset mid-frame: assert reset=0 after 40 samples, release, then send a full ramp.
  - Required: outputs 0 during reset, no burst from the partial frame, and the following frame is output correctly.
- Reset mid-burst: assert reset during output bin 20.
  - Required: odata_en, odata_r and odata_idx go 0 immediately (asynchronously) and the burst does not resume.
- Parameter N=16, WIDTH=8: ramp input k.
  - Required: bin n gives bitrev4(n), e.g. n=1 gives 8, n=5 gives 10; 16-cycle burst.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order
// using a ping-pong buffer; emits one contiguous N-cycle burst per frame.
module fft_bitrev_reorder #(
    parameter  int N     = 64,
    parameter  int WIDTH = 16,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i,
    output logic [LOG2N-1:0] odata_idx,
    output logic             odata_last
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [2*WIDTH-1:0] r_mem [0:2*N-1];
    logic [LOG2N-1:0]   r_wcnt;
    logic [LOG2N-1:0]   r_rcnt;
    logic               r_wsel;
    logic               r_rbank;
    logic               r_frame_done;
    logic [0:0]         r_state;
    logic [LOG2N-1:0]   w_waddr;
    logic               w_wlast;
    logic [2*WIDTH-1:0] w_rdata;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] v;
        v = '0;
        for (int b = 0; b < LOG2N; b++) begin
            v[b] = a[LOG2N-1-b];
        end
        return v;
    endfunction

    assign w_waddr = bitrev(r_wcnt);
    assign w_wlast = idata_en && (r_wcnt == LAST);
    assign w_rdata = r_mem[{r_rbank, r_rcnt}];

    // Storage is never reset; a bank is only read after being fully written.
    always_ff @(posedge clock) begin
        if (idata_en) begin
            r_mem[{r_wsel, w_waddr}] <= {idata_r, idata_i};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wcnt       <= '0;
            r_wsel       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wlast;
            if (idata_en) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_wlast) begin
                r_wsel <= ~r_wsel;
            end
        end
    end

    // The read bank is latched at burst start so the write-side toggle
    // of a back-to-back frame cannot disturb the last read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_frame_done) begin
                        r_state <= S_READ;
                        r_rcnt  <= '0;
                        r_rbank <= ~r_wsel;
                    end
                end
                S_READ: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (r_rcnt == LAST) begin
                        if (r_frame_done) begin
                            r_rbank <= ~r_wsel;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            odata_en   <= 1'b0;
            odata_r    <= '0;
            odata_i    <= '0;
            odata_idx  <= '0;
            odata_last <= 1'b0;
        end else if (r_state == S_READ) begin
            odata_en   <= 1'b1;
            odata_r    <= w_rdata[2*WIDTH-1:WIDTH];
            odata_i    <= w_rdata[WIDTH-1:0];
            odata_idx  <= r_rcnt;
            odata_last <= (r_rcnt == LAST);
        end else begin
            odata_en   <= 1'b0;
            odata_r    <= '0;
            odata_i    <= '0;
            odata_idx  <= '0;
            odata_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=64/W=16 and N=16/W=8).
// Scoreboard of expected bins plus table-driven spot checks.
module tb_fft_bitrev_reorder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        en64;
    logic [15:0] r64, i64;
    logic        o_en64, o_last64;
    logic [15:0] o_r64, o_i64;
    logic [5:0]  o_idx64;

    logic        en16;
    logic [7:0]  r16, i16;
    logic        o_en16, o_last16;
    logic [7:0]  o_r16, o_i16;
    logic [3:0]  o_idx16;

    fft_bitrev_reorder #(.N(64), .WIDTH(16)) dut64 (
        .clock(clock), .reset(reset),
        .idata_en(en64), .idata_r(r64), .idata_i(i64),
        .odata_en(o_en64), .odata_r(o_r64), .odata_i(o_i64),
        .odata_idx(o_idx64), .odata_last(o_last64)
    );

    fft_bitrev_reorder #(.N(16), .WIDTH(8)) dut16 (
        .clock(clock), .reset(reset),
        .idata_en(en16), .idata_r(r16), .idata_i(i16),
        .odata_en(o_en16), .odata_r(o_r16), .odata_i(o_i16),
        .odata_idx(o_idx16), .odata_last(o_last16)
    );

    typedef struct {
        int cyc;
        int r;
        int i;
        int idx;
        bit last;
    } exp_t;

    typedef struct {
        int n;
        int r;
        int i;
    } vec_t;

    exp_t q64[$];
    exp_t q16[$];
    exp_t e64, e16;
    vec_t tab64[7];
    vec_t tab16[6];

    int ntests = 0;
    int nfail  = 0;
    int fr64_r[64], fr64_i[64];
    int fr16_r[16], fr16_i[16];
    int cap64_r[64], cap64_i[64];
    int cap16_r[16], cap16_i[16];
    int wc64 = 0, wc16 = 0;
    int run64 = 0, last_run64 = 0;
    bit found;

    function automatic int brev(int v, int bits);
        int o = 0;
        for (int b = 0; b < bits; b++) begin
            if (v[b]) o |= (1 << (bits - 1 - b));
        end
        return o;
    endfunction

    // Monitor / scoreboard for the N=64 instance
    always @(negedge clock) begin
        ntests++;
        if (o_en64) begin
            run64++;
            cap64_r[o_idx64] = int'(o_r64);
            cap64_i[o_idx64] = int'(o_i64);
            if (q64.size() == 0) begin
                nfail++;
                $display("FAIL unexpected64 cyc=%0d idx=%0d r=%0d required no output",
                         cyc, o_idx64, o_r64);
            end else begin
                e64 = q64.pop_front();
                if (cyc != e64.cyc || int'(o_r64) != e64.r || int'(o_i64) != e64.i ||
                    int'(o_idx64) != e64.idx || o_last64 !== e64.last) begin
                    nfail++;
                    $display("FAIL bin64 got cyc=%0d idx=%0d r=%0d i=%0d last=%0b required cyc=%0d idx=%0d r=%0d i=%0d last=%0b",
                             cyc, o_idx64, o_r64, o_i64, o_last64,
                             e64.cyc, e64.idx, e64.r, e64.i, e64.last);
                end
            end
        end else begin
            if (run64 != 0) last_run64 = run64;
            run64 = 0;
            if (o_en64 !== 1'b0 || o_r64 !== 16'd0 || o_i64 !== 16'd0 ||
                o_idx64 !== 6'd0 || o_last64 !== 1'b0) begin
                nfail++;
                $display("FAIL idle64 got en=%b r=%h i=%h idx=%h last=%b required all 0",
                         o_en64, o_r64, o_i64, o_idx64, o_last64);
            end
        end
    end

    // Monitor / scoreboard for the N=16 instance
    always @(negedge clock) begin
        if (o_en16) begin
            ntests++;
            cap16_r[o_idx16] = int'(o_r16);
            cap16_i[o_idx16] = int'(o_i16);
            if (q16.size() == 0) begin
                nfail++;
                $display("FAIL unexpected16 cyc=%0d idx=%0d required no output", cyc, o_idx16);
            end else begin
                e16 = q16.pop_front();
                if (cyc != e16.cyc || int'(o_r16) != e16.r || int'(o_i16) != e16.i ||
                    int'(o_idx16) != e16.idx || o_last16 !== e16.last) begin
                    nfail++;
                    $display("FAIL bin16 got cyc=%0d idx=%0d r=%0d i=%0d last=%0b required cyc=%0d idx=%0d r=%0d i=%0d last=%0b",
                             cyc, o_idx16, o_r16, o_i16, o_last16,
                             e16.cyc, e16.idx, e16.r, e16.i, e16.last);
                end
            end
        end
    end

    task automatic drv64(input bit en, input int r, input int im);
        exp_t e;
        @(negedge clock);
        en64 = en;
        r64  = 16'(r);
        i64  = 16'(im);
        if (en) begin
            fr64_r[wc64] = r & 16'hFFFF;
            fr64_i[wc64] = im & 16'hFFFF;
            wc64++;
            if (wc64 == 64) begin
                for (int n = 0; n < 64; n++) begin
                    e.cyc  = cyc + 3 + n;
                    e.r    = fr64_r[brev(n, 6)];
                    e.i    = fr64_i[brev(n, 6)];
                    e.idx  = n;
                    e.last = (n == 63);
                    q64.push_back(e);
                end
                wc64 = 0;
            end
        end
    endtask

    task automatic drv16(input bit en, input int r, input int im);
        exp_t e;
        @(negedge clock);
        en16 = en;
        r16  = 8'(r);
        i16  = 8'(im);
        if (en) begin
            fr16_r[wc16] = r & 8'hFF;
            fr16_i[wc16] = im & 8'hFF;
            wc16++;
            if (wc16 == 16) begin
                for (int n = 0; n < 16; n++) begin
                    e.cyc  = cyc + 3 + n;
                    e.r    = fr16_r[brev(n, 4)];
                    e.i    = fr16_i[brev(n, 4)];
                    e.idx  = n;
                    e.last = (n == 15);
                    q16.push_back(e);
                end
                wc16 = 0;
            end
        end
    endtask

    task automatic idle64(input int n);
        for (int k = 0; k < n; k++) drv64(1'b0, 0, 0);
    endtask

    task automatic clear_cap();
        for (int n = 0; n < 64; n++) begin
            cap64_r[n] = -1;
            cap64_i[n] = -1;
        end
        for (int n = 0; n < 16; n++) begin
            cap16_r[n] = -1;
            cap16_i[n] = -1;
        end
    endtask

    task automatic check_tab64(input string name);
        for (int t = 0; t < 7; t++) begin
            ntests++;
            if (cap64_r[tab64[t].n] != tab64[t].r || cap64_i[tab64[t].n] != tab64[t].i) begin
                nfail++;
                $display("FAIL %s bin %0d got r=%0d i=%0d required r=%0d i=%0d",
                         name, tab64[t].n, cap64_r[tab64[t].n], cap64_i[tab64[t].n],
                         tab64[t].r, tab64[t].i);
            end
        end
    endtask

    task automatic async_reset_check(input string name);
        #1 reset = 1'b0;
        en64 = 1'b0;
        q64.delete();
        wc64 = 0;
        #1;
        ntests++;
        if (o_en64 !== 1'b0 || o_r64 !== 16'd0 || o_i64 !== 16'd0 ||
            o_idx64 !== 6'd0 || o_last64 !== 1'b0) begin
            nfail++;
            $display("FAIL %s got en=%b r=%h idx=%h last=%b required all 0",
                     name, o_en64, o_r64, o_idx64, o_last64);
        end
    endtask

    initial begin
        tab64[0] = '{0, 0, 63};
        tab64[1] = '{1, 32, 31};
        tab64[2] = '{2, 16, 47};
        tab64[3] = '{3, 48, 15};
        tab64[4] = '{5, 40, 23};
        tab64[5] = '{62, 31, 32};
        tab64[6] = '{63, 63, 0};
        tab16[0] = '{0, 0, 15};
        tab16[1] = '{1, 8, 7};
        tab16[2] = '{3, 12, 3};
        tab16[3] = '{5, 10, 5};
        tab16[4] = '{6, 6, 9};
        tab16[5] = '{15, 15, 0};

        reset = 1'b0;
        en64 = 1'b0; r64 = '0; i64 = '0;
        en16 = 1'b0; r16 = '0; i16 = '0;
        clear_cap();
        repeat (3) @(negedge clock);
        #1;
        ntests++;
        if (o_en64 !== 1'b0 || o_r64 !== 16'd0 || o_idx64 !== 6'd0 || o_last64 !== 1'b0 ||
            o_en16 !== 1'b0 || o_r16 !== 8'd0 || o_idx16 !== 4'd0 || o_last16 !== 1'b0) begin
            nfail++;
            $display("FAIL reset_state got en64=%b r64=%h en16=%b r16=%h required 0",
                     o_en64, o_r64, o_en16, o_r16);
        end
        @(negedge clock);
        reset = 1'b1;
        idle64(2);

        // Contiguous ramp
        clear_cap();
        for (int k = 0; k < 64; k++) drv64(1'b1, k, 63 - k);
        idle64(70);
        check_tab64("ramp");

        // Three back-to-back frames
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 64; k++) drv64(1'b1, f * 64 + k, 1000 + f * 7 + k);
        end
        idle64(70);
        ntests++;
        if (last_run64 != 192) begin
            nfail++;
            $display("FAIL b2b_run got %0d cycles required 192", last_run64);
        end

        // Gapped ramp
        clear_cap();
        for (int k = 0; k < 64; k++) begin
            drv64(1'b1, k, 63 - k);
            drv64(1'b0, 0, 0);
        end
        idle64(70);
        check_tab64("gapped");

        // Reset after a partial frame
        for (int k = 0; k < 40; k++) drv64(1'b1, 500 + k, k);
        @(negedge clock);
        async_reset_check("rst_midframe");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle64(70);
        for (int k = 0; k < 64; k++) drv64(1'b1, 100 + k, 7 * k);
        idle64(70);

        // Reset during output bin 20
        for (int k = 0; k < 64; k++) drv64(1'b1, 200 + k, 300 + k);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            drv64(1'b0, 0, 0);
            if (o_en64 && o_idx64 == 6'd20) found = 1'b1;
        end
        ntests++;
        if (!found) begin
            nfail++;
            $display("FAIL burst20_timeout got no bin 20 required bin 20 within 100 cycles");
        end
        async_reset_check("rst_midburst");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle64(80);

        // N=16, WIDTH=8 instance
        for (int k = 0; k < 16; k++) drv16(1'b1, k, 15 - k);
        drv16(1'b0, 0, 0);
        repeat (25) @(negedge clock);
        for (int t = 0; t < 6; t++) begin
            ntests++;
            if (cap16_r[tab16[t].n] != tab16[t].r || cap16_i[tab16[t].n] != tab16[t].i) begin
                nfail++;
                $display("FAIL n16 bin %0d got r=%0d i=%0d required r=%0d i=%0d",
                         tab16[t].n, cap16_r[tab16[t].n], cap16_i[tab16[t].n],
                         tab16[t].r, tab16[t].i);
            end
        end

        ntests++;
        if (q64.size() != 0 || q16.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d/%0d pending bins required 0/0", q64.size(), q16.size());
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
